// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Widest supported counter; narrower counters take the low bits of CNT_MAX
    localparam int unsigned CNT_W_MAX = 32;
    localparam logic [CNT_W_MAX-1:0] CNT_MAX = '1;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized signal.
module edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise_c
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sig;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a gate window and captures the first period.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] period_cycles,
    output logic             timeout
);

    localparam int unsigned      WIN_W     = $clog2(GATE_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
    localparam logic [CNT_W-1:0] L_CNT_MAX = CNT_MAX[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic             w_rise;
    logic             w_last;

    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_per_lat;

    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_edge_out;
    logic [CNT_W-1:0] r_per_out;
    logic             r_timeout;

    edge_sync u_sync (
        .i_clk    (clk_in),
        .i_rst    (reset),
        .i_sig    (sig_in),
        .o_rise_c (w_rise)
    );

    // Last cycle of the ARM timeout or of the MEASURE window
    assign w_last = (r_win == WIN_LAST);

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start outside IDLE and start alongside ack in DONE are dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_ARM;
            ST_ARM: begin
                if (w_rise)      w_next = ST_MEASURE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_MEASURE: if (w_last) w_next = ST_DONE;
            ST_DONE:    if (ack) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Window/timeout, edge and period counters; a rise in the final window cycle is ignored
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_win      <= '0;
            r_edge_cnt <= '0;
            r_per_cnt  <= '0;
            r_per_lat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_win      <= '0;
                    r_edge_cnt <= '0;
                    r_per_cnt  <= '0;
                    r_per_lat  <= '0;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        r_win      <= WIN_ONE;
                        r_edge_cnt <= CNT_ONE;
                        r_per_cnt  <= CNT_ONE;
                    end else begin
                        r_win <= r_win + WIN_ONE;
                    end
                end
                ST_MEASURE: begin
                    r_win <= r_win + WIN_ONE;
                    if (!w_last) begin
                        if (w_rise && (r_edge_cnt != L_CNT_MAX)) begin
                            r_edge_cnt <= r_edge_cnt + CNT_ONE;
                        end
                        // Period counter runs only between the first and second rise
                        if (r_edge_cnt == CNT_ONE) begin
                            if (w_rise) begin
                                r_per_lat <= r_per_cnt;
                            end else if (r_per_cnt != L_CNT_MAX) begin
                                r_per_cnt <= r_per_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and results; results move only on entry to and exit from DONE
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_edge_out <= '0;
            r_per_out  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_busy  <= (w_next == ST_ARM) || (w_next == ST_MEASURE);
            r_valid <= (w_next == ST_DONE);
            if ((r_state != ST_DONE) && (w_next == ST_DONE)) begin
                r_edge_out <= r_edge_cnt;
                r_per_out  <= r_per_lat;
                r_timeout  <= (r_state == ST_ARM);
            end else if ((r_state == ST_DONE) && (w_next == ST_IDLE)) begin
                r_edge_out <= '0;
                r_per_out  <= '0;
                r_timeout  <= 1'b0;
            end
        end
    end

    assign busy          = r_busy;
    assign valid         = r_valid;
    assign edge_count    = r_edge_out;
    assign period_cycles = r_per_out;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: expected results queued at start, checked on valid.
module tb_freq_meter;

    localparam int unsigned GATE = 64;
    localparam int unsigned CW   = 16;

    typedef struct {
        int unsigned e;
        int unsigned p;
        bit          t;
    } exp_t;

    logic          clk_in;
    logic          reset;
    logic          sig_in;
    logic          start;
    logic          ack;
    logic          busy;
    logic          valid;
    logic [CW-1:0] edge_count;
    logic [CW-1:0] period_cycles;
    logic          timeout;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   sig_half  = 0;     // 0: hold sig_level, else square wave with this half period
    logic sig_level = 1'b0;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CW)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .sig_in        (sig_in),
        .start         (start),
        .ack           (ack),
        .busy          (busy),
        .valid         (valid),
        .edge_count    (edge_count),
        .period_cycles (period_cycles),
        .timeout       (timeout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Signal generator
    initial begin
        int ph;
        ph     = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (sig_half == 0) begin
                sig_in = sig_level;
                ph     = 0;
            end else begin
                ph++;
                if (ph >= sig_half) begin
                    ph     = 0;
                    sig_in = ~sig_in;
                end
            end
        end
    end

    // Monitor: on each new valid, pop and compare the queued expectation
    initial begin
        logic prev_valid;
        exp_t x;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_in);
            if (valid && !prev_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    x = q.pop_front();
                    check("edge_count", edge_count, x.e);
                    check("period_cycles", period_cycles, x.p);
                    check("timeout", timeout, x.t);
                end
            end
            prev_valid = valid;
        end
    end

    task automatic start_and_wait(input int budget, output int lat, output bit busy_ok);
        start = 1'b1;
        @(negedge clk_in);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!valid && lat < budget) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk_in);
            lat++;
        end
        if (!valid) check("valid_wait_expired", 0, 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk_in);
        ack = 1'b0;
        check("valid_after_ack", valid, 0);
    endtask

    initial begin
        int   lat;
        bit   bok;
        bit   stable;
        logic [CW-1:0] e0;
        logic [CW-1:0] p0;

        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_edge", edge_count, 0);
        check("rst_period", period_cycles, 0);
        reset = 1'b0;
        @(negedge clk_in);

        // Reference: 2 high / 2 low
        sig_half = 2;
        repeat (10) @(negedge clk_in);
        q.push_back('{16, 4, 1'b0});
        start_and_wait(200, lat, bok);
        check("ref_busy_throughout", bok, 1);
        check("ref_busy_at_valid", busy, 0);
        repeat (2) @(negedge clk_in);
        do_ack();

        // Slow: 8 high / 8 low, then handshake behaviour
        sig_half = 8;
        repeat (20) @(negedge clk_in);
        q.push_back('{4, 16, 1'b0});
        start_and_wait(200, lat, bok);
        check("slow_busy_throughout", bok, 1);
        e0 = edge_count;
        p0 = period_cycles;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (!valid || edge_count != e0 || period_cycles != p0 || timeout) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        check("hold_edge", edge_count, 4);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (3) @(negedge clk_in);
        check("start_in_done_valid", valid, 1);
        check("start_in_done_busy", busy, 0);
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        ack   = 1'b0;
        check("start_ack_valid", valid, 0);
        repeat (5) @(negedge clk_in);
        check("start_ack_no_busy", busy, 0);
        check("start_ack_no_valid", valid, 0);

        // Single edge: one rise then held high
        sig_half  = 0;
        sig_level = 1'b0;
        repeat (10) @(negedge clk_in);
        q.push_back('{1, 0, 1'b0});
        fork
            start_and_wait(200, lat, bok);
            begin
                repeat (10) @(negedge clk_in);
                sig_level = 1'b1;
            end
        join
        check("single_busy_throughout", bok, 1);
        do_ack();
        sig_level = 1'b0;

        // No signal: timeout after 1 + GATE cycles
        repeat (10) @(negedge clk_in);
        q.push_back('{0, 0, 1'b1});
        start_and_wait(200, lat, bok);
        check("timeout_latency", lat, 1 + GATE);
        check("timeout_busy_throughout", bok, 1);
        do_ack();

        // Mid-measurement reset, then a clean measurement
        sig_half = 2;
        repeat (10) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (20) @(negedge clk_in);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_edge", edge_count, 0);
        check("mid_rst_period", period_cycles, 0);
        check("mid_rst_timeout", timeout, 0);
        repeat (5) @(negedge clk_in);
        check("mid_rst_idle", busy | valid, 0);
        q.push_back('{16, 4, 1'b0});
        start_and_wait(200, lat, bok);
        check("after_rst_busy_throughout", bok, 1);
        do_ack();

        repeat (5) @(negedge clk_in);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
